// File: rtl/pp_ctrl_pkg.sv
// pp_ctrl_pkg: shared FSM encoding and default pipeline latency for the post-processing stage controller
package pp_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int PIPE_LAT_DEF = 2;
endpackage

// File: rtl/pp_valid_tracker.sv
// pp_valid_tracker: PIPE_LAT-deep shift register marking which stage slots hold real pixels
//   clk, rst (sync, active-low) | advance: shift on a stage beat | din: flag shifted in | tail: flag leaving the stage
module pp_valid_tracker
  import pp_ctrl_pkg::*;
#(
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic advance,
  input  logic din,
  output logic tail
);
  logic [PIPE_LAT-1:0] sr;
  always_ff @(posedge clk)
    if (!rst) sr <= '0;
    else if (advance) sr <= PIPE_LAT'({sr, din});
  assign tail = sr[PIPE_LAT-1];
endmodule

// File: rtl/pp_stage_ctrl.sv
// pp_stage_ctrl: frame-level clock-enable / data-enable controller for a fixed-latency post-processing stage
//   clk, rst (sync, active-low) | start, abort, cfg_width, cfg_height: frame control
//   in_valid/in_ready: upstream pixel handshake | out_ready: downstream back-pressure
//   stage_clken, stage_enable: stage controls | out_valid, out_last: stage output qualifiers
//   col, row: coordinate of the accepted pixel | busy, frame_done, cfg_err: status
module pp_stage_ctrl
  import pp_ctrl_pkg::*;
#(
  parameter int COL_W    = 10,
  parameter int ROW_W    = 9,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [COL_W-1:0] cfg_width,
  input  logic [ROW_W-1:0] cfg_height,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             stage_clken,
  output logic             stage_enable,
  output logic             out_valid,
  output logic             out_last,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             busy,
  output logic             frame_done,
  output logic             cfg_err
);
  localparam int OW = COL_W + ROW_W;
  state_t st, nxt;
  logic [COL_W-1:0] lw;
  logic [ROW_W-1:0] lh;
  logic [OW-1:0] ocnt;
  logic [1:0] dcnt;
  logic idle, run, drain, cfg_ok, beat, last_px, drain_end, tail;
  assign idle         = st == IDLE;
  assign run          = st == RUN;
  assign drain        = st == DRAIN;
  assign busy         = !idle;
  assign frame_done   = st == DONE;
  assign cfg_ok       = |cfg_width && |cfg_height;
  assign in_ready     = run && out_ready;
  assign stage_clken  = (run || drain) && out_ready;
  // DRAIN pushes bubbles so the last real pixels flush out of the stage
  assign stage_enable = run ? in_valid : drain;
  assign beat         = stage_clken && stage_enable;
  assign last_px      = col == lw - COL_W'(1) && row == lh - ROW_W'(1);
  assign drain_end    = dcnt == 2'(PIPE_LAT - 1);
  assign out_valid    = tail && out_ready;
  assign out_last     = out_valid && ocnt == OW'(lw) * OW'(lh) - OW'(1);
  // abort shares the tracker's clear path with reset
  pp_valid_tracker #(.PIPE_LAT(PIPE_LAT)) u_trk (
    .clk,
    .rst(rst && !abort),
    .advance(beat),
    .din(run),
    .tail
  );
  always_ff @(posedge clk) st <= !rst ? IDLE : nxt;
  always_comb begin
    nxt = st;
    unique case (st)
      IDLE:  nxt = start && cfg_ok ? RUN : IDLE;
      RUN:   nxt = beat && last_px ? DRAIN : RUN;
      DRAIN: nxt = beat && drain_end ? DONE : DRAIN;
      DONE:  nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      lw      <= '0;
      lh      <= '0;
      col     <= '0;
      row     <= '0;
      ocnt    <= '0;
      dcnt    <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= idle && start && !abort && !cfg_ok;
      if (abort) begin
        col  <= '0;
        row  <= '0;
        ocnt <= '0;
        dcnt <= '0;
      end else begin
        if (idle && start && cfg_ok) begin
          lw   <= cfg_width;
          lh   <= cfg_height;
          col  <= '0;
          row  <= '0;
          ocnt <= '0;
          dcnt <= '0;
        end
        if (run && beat) begin
          col <= col == lw - COL_W'(1) ? '0 : col + COL_W'(1);
          if (col == lw - COL_W'(1)) row <= row + ROW_W'(1);
        end
        if (drain && beat) dcnt <= dcnt + 2'd1;
        if (out_valid) ocnt <= ocnt + OW'(1);
      end
    end
endmodule

// File: tb/tb_pp_stage_ctrl.sv
// tb_pp_stage_ctrl: scoreboard bench for pp_stage_ctrl with directed frames, stalls, abort, cfg error and reset
module tb_pp_stage_ctrl;
  localparam int PL = 2;
  logic clk = 0, rst = 0, start = 0, abort = 0, in_valid = 0, out_ready = 0;
  logic [9:0] cfg_width = '0;
  logic [8:0] cfg_height = '0;
  logic in_ready, stage_clken, stage_enable, out_valid, out_last, busy, frame_done, cfg_err;
  logic [9:0] col;
  logic [8:0] row;
  int total = 0, bad = 0;
  bit q[$];

  pp_stage_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .in_valid(in_valid), .in_ready(in_ready), .out_ready(out_ready),
    .stage_clken(stage_clken), .stage_enable(stage_enable),
    .out_valid(out_valid), .out_last(out_last), .col(col), .row(row),
    .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  always @(negedge clk)
    if (rst) begin
      if (out_valid) begin
        if (q.size() == 0) chk("sb_extra_output", 1, 0);
        else chk("out_last", out_last, q.pop_front());
      end else if (out_last) chk("last_without_valid", out_last, 0);
    end

  task automatic start_frame(input int w, input int h);
    cfg_width = 10'(w);
    cfg_height = 9'(h);
    start = 1;
    for (int i = 0; i < w * h; i++) q.push_back(i == w * h - 1);
    step();
    start = 0;
  endtask

  task automatic run_frame(input int w, input int h, input int sa, input int sl);
    int n, acc, pb, fd;
    n = w * h; acc = 0; pb = 0; fd = -1;
    in_valid = 1;
    out_ready = 1;
    start_frame(w, h);
    for (int cyc = 0; cyc < 200 && fd < 0; cyc++) begin
      out_ready = !(sl > 0 && cyc >= sa && cyc < sa + sl);
      @(negedge clk);
      if (pb < n + PL) begin
        chk("stage_clken", stage_clken, out_ready);
        chk("out_valid", out_valid, out_ready && pb >= PL);
        chk("stage_enable", stage_enable, 1);
        if (acc < n) begin
          chk("in_ready", in_ready, out_ready);
          chk("col", col, acc % w);
          chk("row", row, acc / w);
        end else chk("in_ready_drain", in_ready, 0);
        if (out_ready) begin
          pb++;
          if (acc < n) acc++;
        end
      end
      if (frame_done) begin
        fd = cyc;
        chk("busy_in_done", busy, 1);
      end
      step();
    end
    chk("frame_done_cycle", fd, n + PL + sl);
    @(negedge clk);
    chk("busy_after", busy, 0);
    chk("frame_done_single", frame_done, 0);
    chk("sb_outputs_left", q.size(), 0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    start = 1; abort = 1; cfg_width = 4; cfg_height = 2; in_valid = 1; out_ready = 1;
    repeat (3) step();
    @(negedge clk);
    chk("reset_outs", {in_ready, stage_clken, stage_enable, out_valid, out_last, busy, frame_done, cfg_err}, 0);
    chk("reset_col", col, 0);
    chk("reset_row", row, 0);
    start = 0; abort = 0; rst = 1;
    step();
    run_frame(4, 2, 0, 0);
    run_frame(4, 2, 4, 3);
    cfg_width = 0; cfg_height = 2; start = 1;
    step();
    start = 0;
    @(negedge clk);
    chk("cfg_err_pulse", cfg_err, 1);
    chk("cfg_err_busy", busy, 0);
    chk("cfg_err_enable", stage_enable, 0);
    step();
    @(negedge clk);
    chk("cfg_err_cleared", cfg_err, 0);
    chk("cfg_err_busy2", busy, 0);
    step();
    run_frame(1, 1, 0, 0);
    in_valid = 1; out_ready = 1;
    start_frame(4, 2);
    step();
    step();
    abort = 1; start = 1; cfg_width = 4; cfg_height = 2;
    @(negedge clk);
    chk("abort_at_col", col, 2);
    chk("abort_at_row", row, 0);
    step();
    abort = 0; start = 0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_col", col, 0);
    chk("abort_out_valid", out_valid, 0);
    q.delete();
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      chk("abort_no_done", frame_done, 0);
      chk("abort_no_valid", out_valid, 0);
    end
    step();
    run_frame(4, 2, 0, 0);
    in_valid = 1; out_ready = 1;
    start_frame(4, 2);
    repeat (8) step();
    @(negedge clk);
    chk("drain_in_ready", in_ready, 0);
    chk("drain_busy", busy, 1);
    rst = 0;
    step();
    @(negedge clk);
    chk("rst_drain_outs", {in_ready, stage_clken, stage_enable, out_valid, out_last, busy, frame_done, cfg_err}, 0);
    chk("rst_drain_col", col, 0);
    chk("rst_drain_row", row, 0);
    q.delete();
    rst = 1;
    step();
    run_frame(3, 1, 1, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
